// File: rtl/mem_stage_dmem.sv
// MEM-stage data access: word-addressed data RAM plus a memory-mapped peripheral window
// holding a reload timer with interrupt, an LED register and a free-running cycle counter.
module mem_stage_dmem #(
  parameter int          RAM_WORDS   = 256,
  parameter int          RAM_AW      = 8,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  led,
  output logic        irq
);

  logic [31:0] mem [RAM_WORDS];
  logic [31:0] th, tl, systick;
  logic [2:0]  tcon;
  logic [7:0]  led_q;

  logic              is_ram, is_periph;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_th, wr_tl, wr_tcon, wr_led;
  logic              ovf;
  logic [31:0]       tl_n;
  logic [2:0]        tcon_n;

  // Peripheral window is 32 bytes; Addr[4:2] selects the register.
  assign is_ram    = (Addr < 32'(RAM_WORDS * 4));
  assign is_periph = (Addr[31:5] == PERIPH_BASE[31:5]);
  assign ram_idx   = Addr[RAM_AW+1:2];

  assign wr_th   = MemWrite && is_periph && (Addr[4:2] == 3'd0);
  assign wr_tl   = MemWrite && is_periph && (Addr[4:2] == 3'd1);
  assign wr_tcon = MemWrite && is_periph && (Addr[4:2] == 3'd2);
  assign wr_led  = MemWrite && is_periph && (Addr[4:2] == 3'd3);

  always_comb begin
    ReadData = 32'd0;
    if (MemRead) begin
      if (is_ram) begin
        ReadData = mem[ram_idx];
      end else if (is_periph) begin
        case (Addr[4:2])
          3'd0:    ReadData = th;
          3'd1:    ReadData = tl;
          3'd2:    ReadData = {29'd0, tcon};
          3'd3:    ReadData = {24'd0, led_q};
          3'd5:    ReadData = systick;
          default: ReadData = 32'd0;
        endcase
      end
    end
  end

  // CPU writes override the timer's own update; a status set by overflow is
  // ORed in after the CPU value so an interrupt is never lost.
  always_comb begin
    ovf  = tcon[0] && (tl == 32'hFFFF_FFFF);
    tl_n = tl;
    if (tcon[0]) tl_n = ovf ? th : tl + 32'd1;
    if (wr_tl) tl_n = WriteData;
    tcon_n = tcon;
    if (wr_tcon) tcon_n = WriteData[2:0];
    if (ovf && tcon[1]) tcon_n[2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= 32'd0;
      tl      <= 32'd0;
      tcon    <= 3'd0;
      led_q   <= 8'd0;
      systick <= 32'd0;
    end else begin
      if (wr_th) th <= WriteData;
      if (wr_led) led_q <= WriteData[7:0];
      tl      <= tl_n;
      tcon    <= tcon_n;
      systick <= systick + 32'd1;
    end
  end

  // RAM is not reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && is_ram) mem[ram_idx] <= WriteData;
  end

  assign led = led_q;
  assign irq = tcon[2];

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench for mem_stage_dmem: stimulus queues expected values tagged with the
// cycle they apply to; a negedge monitor pops and compares them against the DUT.
module tb_mem_stage_dmem;

  localparam logic [31:0] P = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic        irq;

  typedef enum int {K_RD, K_LED, K_IRQ} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    base_cyc = 0;
  int    checks = 0;
  int    failures = 0;

  mem_stage_dmem dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      item_t it;
      logic [31:0] act;
      it = sb.pop_front();
      case (it.kind)
        K_RD:    act = ReadData;
        K_LED:   act = {24'd0, led};
        default: act = {31'd0, irq};
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h (cycle %0d)", it.name, act, it.exp, cyc);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    MemRead = r; MemWrite = w; Addr = a; WriteData = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input string n, input logic [31:0] v);
    sb.push_back('{cyc, K_RD, v, n});
  endtask

  task automatic exp_led(input string n, input logic [7:0] v);
    sb.push_back('{cyc, K_LED, {24'd0, v}, n});
  endtask

  task automatic exp_irq(input string n, input logic v);
    sb.push_back('{cyc, K_IRQ, {31'd0, v}, n});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(0, 1, a, d);
    tick();
    drive(0, 0, 32'd0, 32'd0);
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] v);
    drive(1, 0, a, 32'd0);
    exp_rd(n, v);
    tick();
    drive(0, 0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'd0, 32'd0);
    tick();
    drive(1, 0, P + 32'h4, 32'd0);
    exp_rd("reset_tl", 32'd0);
    exp_led("reset_led", 8'h00);
    exp_irq("reset_irq", 1'b0);
    tick();
    reset = 1'b0;
    base_cyc = cyc;
    drive(0, 0, 32'd0, 32'd0);

    // RAM store/load
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
    rd("ram_rd_unaligned", 32'h13, 32'hDEAD_BEEF);
    drive(0, 0, 32'h10, 32'd0); exp_rd("rd_gated", 32'd0); tick();
    drive(1, 1, 32'h10, 32'h1234_5678); exp_rd("ram_rd_prewrite", 32'hDEAD_BEEF); tick();
    rd("ram_rd_after_rw", 32'h10, 32'h1234_5678);

    // Timer reload with interrupt
    wr(P + 32'h0, 32'hFFFF_FFFC);
    wr(P + 32'h4, 32'hFFFF_FFFE);
    wr(P + 32'h8, 32'h3);
    drive(1, 0, P + 32'h4, 0); exp_rd("tl_fe", 32'hFFFF_FFFE); exp_irq("irq_pre0", 1'b0); tick();
    drive(1, 0, P + 32'h4, 0); exp_rd("tl_ff", 32'hFFFF_FFFF); exp_irq("irq_pre1", 1'b0); tick();
    drive(1, 0, P + 32'h4, 0); exp_rd("tl_reload", 32'hFFFF_FFFC); exp_irq("irq_set", 1'b1); tick();
    drive(0, 1, P + 32'h8, 32'h3); exp_irq("irq_held", 1'b1); tick();
    drive(1, 0, P + 32'h8, 0); exp_rd("tcon_cleared", 32'h3); exp_irq("irq_cleared", 1'b0); tick();

    // Clear-write collides with overflow: status must survive
    drive(0, 1, P + 32'h8, 32'h3); exp_irq("irq_coll_pre", 1'b0); tick();
    drive(1, 0, P + 32'h4, 0); exp_rd("tl_coll_reload", 32'hFFFF_FFFC); exp_irq("irq_coll", 1'b1); tick();
    rd("tcon_coll", P + 32'h8, 32'h7);

    // Overflow with interrupt disabled
    wr(P + 32'h8, 32'h0);
    wr(P + 32'h4, 32'hFFFF_FFFE);
    wr(P + 32'h8, 32'h1);
    drive(1, 0, P + 32'h4, 0); exp_rd("noie_fe", 32'hFFFF_FFFE); exp_irq("noie_irq0", 1'b0); tick();
    drive(1, 0, P + 32'h4, 0); exp_rd("noie_ff", 32'hFFFF_FFFF); tick();
    drive(1, 0, P + 32'h4, 0); exp_rd("noie_reload", 32'hFFFF_FFFC); exp_irq("noie_irq1", 1'b0); tick();
    rd("noie_fd", P + 32'h4, 32'hFFFF_FFFD);

    // Disable freezes TL (TL increments on the disabling edge itself)
    wr(P + 32'h8, 32'h0);
    rd("frozen0", P + 32'h4, 32'hFFFF_FFFF);
    rd("frozen1", P + 32'h4, 32'hFFFF_FFFF);

    // CPU write to TL beats the reload; CPU write to TH during reload
    wr(P + 32'h8, 32'h1);
    wr(P + 32'h4, 32'h0000_0100);
    rd("tl_wr", P + 32'h4, 32'h0000_0100);
    rd("tl_wr_inc", P + 32'h4, 32'h0000_0101);
    wr(P + 32'h4, 32'hFFFF_FFFF);
    wr(P + 32'h0, 32'h0000_0055);
    rd("th_coll_tl", P + 32'h4, 32'hFFFF_FFFC);
    rd("th_coll_th", P + 32'h0, 32'h0000_0055);
    wr(P + 32'h8, 32'h0);

    // LED, SYSTICK, unmapped addresses
    wr(P + 32'hC, 32'h0000_01A5);
    drive(1, 0, P + 32'hC, 0); exp_rd("led_rd", 32'h0000_00A5); exp_led("led_pin", 8'hA5); tick();
    drive(1, 1, P + 32'h14, 32'h0); exp_rd("systick0", 32'(cyc - base_cyc)); tick();
    rd("systick_wr_ignored", P + 32'h14, 32'(cyc - base_cyc));
    repeat (4) tick();
    rd("systick5", P + 32'h14, 32'(cyc - base_cyc));
    rd("unmapped_10", P + 32'h10, 32'd0);
    wr(P + 32'h18, 32'hFFFF_FFFF);
    rd("unmapped_18", P + 32'h18, 32'd0);
    rd("unmapped_hi", 32'h0000_0400, 32'd0);

    // Async reset mid-operation
    wr(32'h20, 32'h1111_1111);
    wr(P + 32'h4, 32'hFFFF_FFFF);
    wr(P + 32'h8, 32'h3);
    wr(P + 32'hC, 32'hFF);
    drive(0, 0, 0, 0); exp_irq("pre_rst_irq", 1'b1); exp_led("pre_rst_led", 8'hFF); tick();
    #1 reset = 1'b1;
    drive(1, 0, P + 32'h4, 0);
    exp_rd("rst_tl", 32'd0); exp_irq("rst_irq", 1'b0); exp_led("rst_led", 8'h00);
    tick();
    drive(1, 1, P + 32'hC, 32'h55); exp_rd("rst_led_store", 32'd0); tick();
    drive(1, 1, 32'h20, 32'h2222_2222); exp_rd("rst_ram_keep", 32'h1111_1111); tick();
    drive(1, 0, P + 32'h8, 0); exp_rd("rst_tcon", 32'd0); tick();
    reset = 1'b0;
    base_cyc = cyc;
    rd("rst_systick", P + 32'h14, 32'd0);
    drive(1, 0, P + 32'hC, 0); exp_rd("post_rst_led", 32'd0); exp_led("post_rst_led_pin", 8'h00); tick();
    rd("post_rst_ram", 32'h20, 32'h1111_1111);
    rd("post_rst_tcon", P + 32'h8, 32'd0);

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
